usr_shift_ctrl: RTL and testbench
=================================

Name: usr_shift_ctrl

Overview:
- Upstream sequencer for the team's 8-bit universal shift register.
- Accepts bytes over a valid/ready handshake and drives the register's clr/sel/data_in/left_in/right_in.
- Parallel-loads each byte, then paces eight shifts at a programmable bit period, turning the register into a serializer.
- Reads the register's parallel output back to present the current serial bit with a valid strobe.

Parameters:
- WIDTH, 8, data width; must match the shift register width.
- DIV_W, 8, width of the bit-period divider input.
- FILL, 1'b0, value driven on sr_left_in and sr_right_in (shift-in fill bit).

Ports:
- clk  input  1  rising-edge clock, shared with the shift register.
- clr_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream byte valid.
- in_ready  output  1  block can accept a byte.
- in_data  input  WIDTH  byte to serialize.
- in_msb_first  input  1  1 = MSB first (left shift), 0 = LSB first (right shift).
- bit_div  input  DIV_W  bit period = bit_div+1 clocks.
- sr_clr  output  1  drives shift register clr (active-high, synchronous in that block).
- sr_sel  output  2  drives shift register sel: 00 hold, 01 right, 10 left, 11 load.
- sr_data  output  WIDTH  drives shift register data_in.
- sr_left_in  output  1  constant FILL.
- sr_right_in  output  1  constant FILL.
- sr_out  input  WIDTH  shift register parallel output.
- ser_out  output  1  current serial bit.
- ser_valid  output  1  ser_out carries a frame bit.
- busy  output  1  a frame is in progress (LOAD or SHIFT).
- done  output  1  one-cycle pulse after the last bit period.

Behaviour:
- Reset (clr_n low, asynchronous):
  - State goes to INIT.
  - Outputs: in_ready=0, sr_sel=00, sr_data=0, ser_valid=0, busy=0, done=0.
  - Internal byte, direction, divider and counters are cleared.
- INIT: sr_clr=1 for exactly one cycle after reset release, then IDLE. sr_clr is 0 in every other state.
- IDLE:
  - in_ready=1, sr_sel=00.
  - On in_valid&&in_ready, latch in_data, in_msb_first and bit_div, then go to LOAD.
  - bit_div is sampled only at accept.
- LOAD: one cycle with sr_sel=11, sr_data=latched byte, busy=1. Then go to SHIFT with bit_cnt=0 and div_cnt=0.
- SHIFT:
  - busy=1, ser_valid=1.
  - ser_out = msb_first ? sr_out[WIDTH-1] : sr_out[0].
  - div_cnt counts 0..bit_div; sr_sel=00 while div_cnt<bit_div.
  - When div_cnt==bit_div and bit_cnt<WIDTH-1: sr_sel=10 (msb_first) or 01 (lsb_first), div_cnt<=0, bit_cnt++.
  - When div_cnt==bit_div and bit_cnt==WIDTH-1: sr_sel=00 (no final shift), go to DONE.
- DONE: done=1, ser_valid=0, busy=0, sr_sel=00 for one cycle, then IDLE.
- Timing, with accept on the clock edge ending cycle T and D = sampled bit_div:
  - LOAD in cycle T+1.
  - Bit k occupies cycles T+2+k(D+1) through T+2+(k+1)(D+1)-1.
  - done in cycle T+2+8(D+1); in_ready back high the cycle after done.
  - Minimum byte-to-byte spacing is 8(D+1)+3 cycles.
- bit_div=0: one cycle per bit, shift issued every SHIFT cycle except the last. bit_div all-ones: 2^DIV_W cycles per bit; div_cnt must not overflow.
- in_valid outside IDLE is ignored (in_ready=0) and is not latched. Upstream holds in_data until accepted.
- All outputs are registered or decoded from state only; there are no combinational paths from in_valid to any output except none (in_ready depends on state only).
- Reset mid-frame: outputs drop immediately (asynchronous), the frame is abandoned, and INIT clears the shift register on release.

Test Plan:
- Reset release -> sr_clr=1 for one cycle, sr_out=0x00, in_ready=1 in the following cycle.
- in_data=0x2D, msb_first=0, bit_div=0 -> sr_sel=11 one cycle, ser_out 1,0,1,1,0,1,0,0 on 8 consecutive cycles with ser_valid=1, then done pulse.
- in_data=0x2D, msb_first=1, bit_div=2 -> ser_out 0,0,1,0,1,1,0,1, each held 3 cycles (24 cycles), sr_sel=10 every third cycle (7 shifts total), done at T+26.
- Back-to-back 0xFF then 0x00 with in_valid held high -> second accept the cycle after in_ready returns; in_data changes during the first frame do not corrupt it.
- clr_n pulsed low at bit 4 of a 0xA5 frame -> busy, ser_valid and in_ready go to 0 immediately; after release, INIT clears the register and the next byte serializes correctly.
- bit_div=8'hFF, in_data=0x80, msb_first=1 -> first bit 1 lasting 256 cycles, then seven 0 bits of 256 cycles each, with no divider wrap errors.

Source files
------------

// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: byte serializer sequencer for the 8-bit universal shift register.
// Ports: in_* byte handshake, bit_div pacing, sr_* register control/readback, ser_*/busy/done status.
module usr_shift_ctrl #(
  parameter int   WIDTH = 8,
  parameter int   DIV_W = 8,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic [DIV_W-1:0] bit_div,
  output logic             sr_clr,
  output logic [1:0]       sr_sel,
  output logic [WIDTH-1:0] sr_data,
  output logic             sr_left_in,
  output logic             sr_right_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] byte_q;
  logic             msb_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [CW-1:0]    bit_cnt;

  logic period_end;
  logic last_bit;

  // div_cnt never passes div_q, so it cannot wrap even at all-ones
  assign period_end = (div_cnt == div_q);
  assign last_bit   = (bit_cnt == CW'(WIDTH - 1));

  assign sr_left_in  = FILL;
  assign sr_right_in = FILL;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= INIT;
      byte_q  <= '0;
      msb_q   <= 1'b0;
      div_q   <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            byte_q <= in_data;
            msb_q  <= in_msb_first;
            div_q  <= bit_div;
          end
        end
        LOAD: begin
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (period_end) begin
            div_cnt <= '0;
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    sr_clr    = 1'b0;
    sr_sel    = SEL_HOLD;
    sr_data   = '0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      INIT: begin
        sr_clr   = 1'b1;
        state_nx = IDLE;
      end
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        sr_sel   = SEL_LOAD;
        sr_data  = byte_q;
        state_nx = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        ser_valid = 1'b1;
        ser_out   = msb_q ? sr_out[WIDTH-1] : sr_out[0];
        if (period_end) begin
          if (last_bit) begin
            state_nx = DONE;
          end else begin
            sr_sel = msb_q ? SEL_LEFT : SEL_RIGHT;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = INIT;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// tb_usr_shift_ctrl: scoreboard bench for usr_shift_ctrl driving a model shift register.
// Expected frames are built from byte/direction/period at accept and checked per cycle.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_msb_first;
  logic [7:0] bit_div;
  logic       sr_clr;
  logic [1:0] sr_sel;
  logic [7:0] sr_data;
  logic       sr_left_in;
  logic       sr_right_in;
  logic [7:0] sr_q = 8'hC3;
  logic       ser_out;
  logic       ser_valid;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } item_t;

  item_t q[$];
  int    sh_cnt = 0;
  logic  cur_msb = 1'b0;
  int    rdy_due = -1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  usr_shift_ctrl #(.WIDTH(8), .DIV_W(8), .FILL(1'b0)) dut (
    .clk          (clk),
    .clr_n        (clr_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .bit_div      (bit_div),
    .sr_clr       (sr_clr),
    .sr_sel       (sr_sel),
    .sr_data      (sr_data),
    .sr_left_in   (sr_left_in),
    .sr_right_in  (sr_right_in),
    .sr_out       (sr_q),
    .ser_out      (ser_out),
    .ser_valid    (ser_valid),
    .busy         (busy),
    .done         (done)
  );

  // universal shift register the block is meant to drive
  always @(posedge clk) begin
    if (sr_clr) sr_q <= 8'h00;
    else begin
      case (sr_sel)
        2'b11:   sr_q <= sr_data;
        2'b10:   sr_q <= {sr_q[6:0], sr_left_in};
        2'b01:   sr_q <= {sr_right_in, sr_q[7:1]};
        default: ;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    item_t it;
    int    ok;
    int    ov;
    int    t;
    int    d;
    int    b;
    if (!clr_n) begin
      q.delete();
      sh_cnt  = 0;
      rdy_due = -1;
    end else begin
      if (in_valid && in_ready) begin
        t = cyc;
        d = int'(bit_div);
        cur_msb = in_msb_first;
        it.kind = 0; it.val = int'(in_data); it.cyc = t + 1;
        q.push_back(it);
        for (int k = 0; k < 8; k++) begin
          b = in_msb_first ? int'(in_data[7-k]) : int'(in_data[k]);
          for (int j = 0; j <= d; j++) begin
            it.kind = 1; it.val = b; it.cyc = t + 2 + k * (d + 1) + j;
            q.push_back(it);
          end
        end
        it.kind = 2; it.val = 0; it.cyc = t + 2 + 8 * (d + 1);
        q.push_back(it);
      end
      if (cyc == rdy_due) chk("ready_after_done", int'(in_ready), 1);
      if (sr_sel == 2'b10 || sr_sel == 2'b01) begin
        sh_cnt++;
        chk("shift_dir", int'(sr_sel), cur_msb ? 2 : 1);
      end
      if (sr_sel == 2'b11 || ser_valid || done) begin
        if (sr_sel == 2'b11) begin ok = 0; ov = int'(sr_data); end
        else if (ser_valid) begin ok = 1; ov = int'(ser_out); end
        else begin ok = 2; ov = 0; end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: kind %0d val %0h at cycle %0d, none required",
                   ok, ov, cyc);
        end else begin
          it = q.pop_front();
          if (it.kind != ok || it.val != ov || it.cyc != cyc) begin
            errors++;
            $display("FAIL frame_item: got kind %0d val %0h cycle %0d, required kind %0d val %0h cycle %0d",
                     ok, ov, cyc, it.kind, it.val, it.cyc);
          end
        end
        if (ok == 1) chk("busy_in_shift", int'(busy), 1);
        if (ok == 2) begin
          chk("shift_count", sh_cnt, 7);
          chk("busy_at_done", int'(busy), 0);
          sh_cnt  = 0;
          rdy_due = cyc + 1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic m, input logic [7:0] dv,
                      input bit hold);
    int n;
    n = 0;
    in_data = d;
    in_msb_first = m;
    bit_div = dv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      in_valid = hold;
      in_data = 8'($urandom);
      in_msb_first = 1'($urandom);
      bit_div = 8'($urandom);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clr_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_msb_first = 1'b0;
    bit_div = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ser_valid", int'(ser_valid), 0);
    chk("rst_sr_sel", int'(sr_sel), 0);
    chk("rst_sr_data", int'(sr_data), 0);
    chk("rst_done", int'(done), 0);
    @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
    chk("init_sr_clr", int'(sr_clr), 1);
    chk("init_in_ready", int'(in_ready), 0);
    @(negedge clk);
    chk("idle_sr_clr", int'(sr_clr), 0);
    chk("idle_in_ready", int'(in_ready), 1);
    chk("cleared_reg", int'(sr_q), 0);

    send(8'h2D, 1'b0, 8'd0, 1'b0);
    wait_idle();
    send(8'h2D, 1'b1, 8'd2, 1'b0);
    wait_idle();
    send(8'hFF, 1'b1, 8'd1, 1'b1);
    send(8'h00, 1'b0, 8'd1, 1'b0);
    wait_idle();

    send(8'hA5, 1'b1, 8'd1, 1'b0);
    repeat (9) @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ser_valid", int'(ser_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 clr_n = 1'b1;
    @(negedge clk);
    chk("reinit_sr_clr", int'(sr_clr), 1);
    @(negedge clk);
    chk("reinit_cleared", int'(sr_q), 0);
    chk("reinit_in_ready", int'(in_ready), 1);
    send(8'h3C, 1'b0, 8'd3, 1'b0);
    wait_idle();

    send(8'h80, 1'b1, 8'hFF, 1'b0);
    wait_idle();

    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'($urandom), 8'($urandom_range(0, 5)), 1'($urandom));
    end
    in_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
